axi_ar_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI read-address (AR) channel between NUM_MASTERS requesters.
- Latches the winning request into an output register and drives it on the shared AR channel until the handshake completes.
- Caps in-flight read bursts at MAX_OUTSTANDING by counting R-channel last beats.
- Sits between the traffic-generating masters and the slave-side AR channel in the AXI environment.

---
 rtl/axi_ar_arbiter_if.sv | 51 +++++
 rtl/axi_ar_arbiter.sv | 125 ++++++++++++
 tb/tb_axi_ar_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ar_arbiter_if.sv
// Bundle of the shared AR channel, per-master request lanes and R-channel monitor taps.
// The slave modport is the arbiter's view; the master modport is the surrounding environment's view.
interface axi_ar_arbiter_if #(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 32,
  parameter int MAX_OUTSTANDING = 8
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_MASTERS-1:0]            s_arvalid;
  logic [NUM_MASTERS-1:0]            s_arready;
  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_arid;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr;
  logic [NUM_MASTERS*8-1:0]          s_arlen;
  logic [NUM_MASTERS*3-1:0]          s_arsize;
  logic [NUM_MASTERS*2-1:0]          s_arburst;
  logic [NUM_MASTERS*4-1:0]          s_arqos;

  logic                  m_arvalid;
  logic                  m_arready;
  logic [ID_WIDTH-1:0]   m_arid;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic [3:0]            m_arqos;
  logic [IDX_W-1:0]      m_grant;

  logic                  rvalid;
  logic                  rready;
  logic                  rlast;

  logic [CNT_W-1:0]      outstanding;
  logic                  err_underflow;

  modport slave (
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arqos,
    input  m_arready, rvalid, rready, rlast,
    output s_arready, m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arqos,
    output m_grant, outstanding, err_underflow
  );

  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arqos,
    output m_arready, rvalid, rready, rlast,
    input  s_arready, m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arqos,
    input  m_grant, outstanding, err_underflow
  );
endinterface

// File: rtl/axi_ar_arbiter.sv
// Round-robin AR-channel arbiter with a registered output stage and an outstanding-burst cap.
// Optional macro AXI_AR_ARB_QOS_EN restricts arbitration to the highest-arqos valid requesters.
module axi_ar_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic              sig_clock,
  input logic              sig_reset,
  axi_ar_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state, state_n;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       cand;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   found;
  logic                   grant;
  logic                   ar_fire;
  logic                   r_done;
  logic [CNT_W-1:0]       count;

`ifdef AXI_AR_ARB_QOS_EN
  logic [3:0] max_qos;

  always_comb begin
    max_qos  = '0;
    eligible = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (bus.s_arvalid[i] && bus.s_arqos[i*4 +: 4] > max_qos) max_qos = bus.s_arqos[i*4 +: 4];
    for (int i = 0; i < NUM_MASTERS; i++)
      eligible[i] = bus.s_arvalid[i] && (bus.s_arqos[i*4 +: 4] == max_qos);
  end
`else
  assign eligible = bus.s_arvalid;
`endif

  // First eligible index at or above rr_ptr, wrapping modulo NUM_MASTERS.
  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!found && eligible[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // The cap uses the registered count, so an rlast beat this cycle only frees a slot next cycle.
  assign grant   = sig_reset && (state == IDLE) && found && (count < CNT_W'(MAX_OUTSTANDING));
  assign ar_fire = bus.m_arvalid && bus.m_arready;
  assign r_done  = bus.rvalid && bus.rready && bus.rlast;

  always_comb begin
    bus.s_arready = '0;
    if (grant) bus.s_arready[winner] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sig_clock or negedge sig_reset) begin
    if (!sig_reset) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (grant) state_n = HOLD;
      HOLD:    if (bus.m_arready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Decoded straight from the state flop, so an async reset drops it without waiting for a clock.
  assign bus.m_arvalid = (state == HOLD);

  // NOTE: the payload register is reset too, because the channel must present all-zero fields out of reset.
  always_ff @(posedge sig_clock or negedge sig_reset) begin
    if (!sig_reset) begin
      bus.m_arid    <= '0;
      bus.m_araddr  <= '0;
      bus.m_arlen   <= '0;
      bus.m_arsize  <= '0;
      bus.m_arburst <= '0;
      bus.m_arqos   <= '0;
      bus.m_grant   <= '0;
      rr_ptr        <= '0;
    end else if (grant) begin
      bus.m_arid    <= bus.s_arid[winner*ID_WIDTH +: ID_WIDTH];
      bus.m_araddr  <= bus.s_araddr[winner*ADDR_WIDTH +: ADDR_WIDTH];
      bus.m_arlen   <= bus.s_arlen[winner*8 +: 8];
      bus.m_arsize  <= bus.s_arsize[winner*3 +: 3];
      bus.m_arburst <= bus.s_arburst[winner*2 +: 2];
      bus.m_arqos   <= bus.s_arqos[winner*4 +: 4];
      bus.m_grant   <= winner;
      rr_ptr        <= IDX_W'((int'(winner) + 1) % NUM_MASTERS);
    end
  end

  // Simultaneous issue and completion cancel; a completion with nothing in flight is an error.
  always_ff @(posedge sig_clock or negedge sig_reset) begin
    if (!sig_reset) begin
      count             <= '0;
      bus.err_underflow <= 1'b0;
    end else if (ar_fire && !r_done) begin
      count <= count + CNT_W'(1);
    end else if (r_done && !ar_fire) begin
      if (count == '0) bus.err_underflow <= 1'b1;
      else             count <= count - CNT_W'(1);
    end
  end

  assign bus.outstanding = count;

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed self-checking bench for axi_ar_arbiter: reset, single grant, rotation,
// async reset in HOLD, outstanding cap, simultaneous inc/dec, underflow and qos/round-robin order.
module tb_axi_ar_arbiter;
  localparam int NM = 4;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int MO = 8;
`ifdef AXI_AR_ARB_QOS_EN
  localparam bit QOS = 1'b1;
`else
  localparam bit QOS = 1'b0;
`endif

  logic sig_clock = 1'b0;
  logic sig_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  axi_ar_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)) bus ();

  axi_ar_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)) dut (
    .sig_clock (sig_clock),
    .sig_reset (sig_reset),
    .bus       (bus)
  );

  always #5 sig_clock = ~sig_clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge sig_clock);
    #1;
  endtask

  task automatic set_req(input int m, input logic v, input logic [IW-1:0] id,
                         input logic [AW-1:0] addr, input logic [7:0] len, input logic [3:0] qos);
    bus.s_arvalid[m]          = v;
    bus.s_arid[m*IW +: IW]    = id;
    bus.s_araddr[m*AW +: AW]  = addr;
    bus.s_arlen[m*8 +: 8]     = len;
    bus.s_arsize[m*3 +: 3]    = 3'd2;
    bus.s_arburst[m*2 +: 2]   = 2'd1;
    bus.s_arqos[m*4 +: 4]     = qos;
  endtask

  task automatic idle_inputs();
    bus.s_arvalid = '0;
    bus.s_arid    = '0;
    bus.s_araddr  = '0;
    bus.s_arlen   = '0;
    bus.s_arsize  = '0;
    bus.s_arburst = '0;
    bus.s_arqos   = '0;
    bus.m_arready = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rready    = 1'b0;
    bus.rlast     = 1'b0;
  endtask

  task automatic set_r(input logic v);
    bus.rvalid = v;
    bus.rready = v;
    bus.rlast  = v;
  endtask

  task automatic do_reset();
    idle_inputs();
    sig_reset = 1'b0;
    @(negedge sig_clock);
    @(negedge sig_clock);
    sig_reset = 1'b1;
    step();
  endtask

  int e2, e3;

  initial begin
    e2 = QOS ? 1 : 0;
    e3 = QOS ? 0 : 1;

    // Reset state, with a request pending that must not be accepted
    idle_inputs();
    set_req(0, 1'b1, 'h7, 'hABCD, 8'd1, 4'd0);
    repeat (2) @(posedge sig_clock);
    #1;
    check("rst_arvalid", bus.m_arvalid, 0);
    check("rst_arready", bus.s_arready, 0);
    check("rst_araddr", bus.m_araddr, 0);
    check("rst_grant", bus.m_grant, 0);
    check("rst_outstanding", bus.outstanding, 0);
    check("rst_err", bus.err_underflow, 0);
    idle_inputs();
    @(negedge sig_clock);
    sig_reset = 1'b1;
    step();

    // Master 2 alone: accept pulse in cycle 0, registered payload from cycle 1
    set_req(2, 1'b1, 'h22, 'h1000, 8'd3, 4'd5);
    #1;
    check("t1_arready", bus.s_arready, 4'b0100);
    step();
    bus.s_arvalid[2] = 1'b0;
    #1;
    check("t1_arvalid", bus.m_arvalid, 1);
    check("t1_araddr", bus.m_araddr, 'h1000);
    check("t1_arlen", bus.m_arlen, 3);
    check("t1_arid", bus.m_arid, 'h22);
    check("t1_arqos", bus.m_arqos, 5);
    check("t1_grant", bus.m_grant, 2);
    check("t1_hold_arready", bus.s_arready, 0);
    step();
    check("t1_stall_arvalid", bus.m_arvalid, 1);
    check("t1_stall_araddr", bus.m_araddr, 'h1000);
    bus.m_arready = 1'b1;
    step();
    bus.m_arready = 1'b0;
    check("t1_done_arvalid", bus.m_arvalid, 0);
    check("t1_outstanding", bus.outstanding, 1);

    // Async reset while holding a request
    set_req(0, 1'b1, 'h5, 'h2000, 8'd0, 4'd0);
    step();
    bus.s_arvalid[0] = 1'b0;
    check("rh_arvalid_before", bus.m_arvalid, 1);
    #2;
    sig_reset = 1'b0;
    #1;
    check("rh_arvalid_async", bus.m_arvalid, 0);
    check("rh_outstanding", bus.outstanding, 0);
    check("rh_araddr", bus.m_araddr, 0);
    @(negedge sig_clock);
    @(negedge sig_clock);
    sig_reset = 1'b1;
    step();

    // All four valid, ready always high: order 0,1,2,3,0, one grant per two cycles
    for (int m = 0; m < NM; m++) set_req(m, 1'b1, IW'(32'h10 + m), AW'(32'h100 * (m + 1)), 8'(m), 4'd0);
    bus.m_arready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_arready", bus.s_arready, 64'(1) << (k % NM));
      step();
      check("rr_arvalid", bus.m_arvalid, 1);
      check("rr_grant", bus.m_grant, k % NM);
      check("rr_araddr", bus.m_araddr, 'h100 * ((k % NM) + 1));
      check("rr_hold_arready", bus.s_arready, 0);
      step();
      if (k == 4) bus.s_arvalid = '0;
      check("rr_idle_arvalid", bus.m_arvalid, 0);
    end
    check("rr_outstanding", bus.outstanding, 5);

    // Handshake and rlast in the same cycle at outstanding=5
    set_req(1, 1'b1, 'h31, 'h3100, 8'd0, 4'd0);
    step();
    bus.s_arvalid[1] = 1'b0;
    check("sim_grant", bus.m_grant, 1);
    set_r(1'b1);
    step();
    set_r(1'b0);
    check("sim_outstanding", bus.outstanding, 5);
    check("sim_arvalid", bus.m_arvalid, 0);

    // Fill to MAX_OUTSTANDING, then a ninth request waits for one rlast
    do_reset();
    for (int m = 0; m < NM; m++) set_req(m, 1'b1, IW'(m), AW'(32'h40 * m), 8'd0, 4'd0);
    bus.m_arready = 1'b1;
    repeat (16) step();
    check("full_outstanding", bus.outstanding, 8);
    check("full_arvalid", bus.m_arvalid, 0);
    check("full_arready", bus.s_arready, 0);
    step();
    check("full_stall_arvalid", bus.m_arvalid, 0);
    set_r(1'b1);
    #1;
    check("full_same_cycle_arready", bus.s_arready, 0);
    step();
    set_r(1'b0);
    #1;
    check("full_dec_outstanding", bus.outstanding, 7);
    check("full_resume_arready", bus.s_arready, 4'b0001);
    step();
    bus.s_arvalid = '0;
    check("full_resume_arvalid", bus.m_arvalid, 1);
    check("full_resume_grant", bus.m_grant, 0);
    step();
    check("full_refill", bus.outstanding, 8);

    // Underflow is sticky and the counter holds at zero
    do_reset();
    check("uf_err_before", bus.err_underflow, 0);
    set_r(1'b1);
    step();
    set_r(1'b0);
    check("uf_outstanding", bus.outstanding, 0);
    check("uf_err", bus.err_underflow, 1);
    repeat (3) step();
    check("uf_err_sticky", bus.err_underflow, 1);

    // rr pointer at 2, masters 0,1,3 valid with qos 2,7,7; each drops after its grant
    do_reset();
    bus.m_arready = 1'b1;
    set_req(1, 1'b1, 'h1, 'h3000, 8'd0, 4'd0);
    step();
    bus.s_arvalid[1] = 1'b0;
    check("q_setup_grant", bus.m_grant, 1);
    step();
    set_req(0, 1'b1, 'hA0, 'h5000, 8'd0, 4'd2);
    set_req(1, 1'b1, 'hA1, 'h5100, 8'd0, 4'd7);
    set_req(3, 1'b1, 'hA3, 'h5300, 8'd0, 4'd7);
    #1;
    check("q_first_arready", bus.s_arready, 4'b1000);
    step();
    bus.s_arvalid[3] = 1'b0;
    check("q_first_grant", bus.m_grant, 3);
    check("q_first_qos", bus.m_arqos, 7);
    step();
    #1;
    check("q_second_arready", bus.s_arready, 64'(1) << e2);
    step();
    bus.s_arvalid[e2] = 1'b0;
    check("q_second_grant", bus.m_grant, e2);
    step();
    #1;
    check("q_third_arready", bus.s_arready, 64'(1) << e3);
    step();
    bus.s_arvalid = '0;
    check("q_third_grant", bus.m_grant, e3);
    check("q_third_qos", bus.m_arqos, (e3 == 0) ? 2 : 7);
    step();
    check("q_outstanding", bus.outstanding, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
